// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-memory responder and its latency counter.
package mem_pkg;
   localparam int WORD_W      = 32;
   localparam int BYTE_OFF_W  = 2;
   localparam int LATENCY_MAX = 15;
   localparam int CNT_W       = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;
endpackage

// File: rtl/data_mem_responder_lat_counter.sv
// Down-counter that times the WAIT phase; loads on accept, decrements to zero and holds.
module mem_lat_counter
   import mem_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency responder for the pipeline data-memory port: one request in flight,
// registered one-cycle ack carrying load data or a fault flag.
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [WORD_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic              ready_o,
   output logic              ack_o,
   output logic [WORD_W-1:0] rdata_o,
   output logic              err_o
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY >= 2) ? CNT_W'(LATENCY - 2) : '0;

   if (LATENCY < 1 || LATENCY > LATENCY_MAX) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be within 1..15");
   end
   if (DEPTH_WORDS < 4 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
      $error("data_mem_responder: DEPTH_WORDS must be a power of two >= 4");
   end

   state_e            state_q;
   logic              we_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic              ack_q;
   logic              err_q;
   logic [WORD_W-1:0] rdata_q;
   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

   logic              cnt_zero;
   logic              accept;
   logic              enter_resp;
   logic              sel_we;
   logic [WORD_W-1:0] sel_addr;
   logic [WORD_W-1:0] sel_wdata;
   logic              sel_fault;
   logic [IDX_W-1:0]  sel_idx;

   assign accept     = (state_q == IDLE) && req_i && !rst_i;
   assign enter_resp = (LATENCY == 1) ? accept : ((state_q == WAIT) && cnt_zero);

   // With LATENCY==1 the RESP-entry edge is the accept edge, so the live inputs are used.
   always_comb begin
      sel_we    = we_q;
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
      if (state_q == IDLE) begin
         sel_we    = we_i;
         sel_addr  = addr_i;
         sel_wdata = wdata_i;
      end
   end

   assign sel_idx   = sel_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];
   assign sel_fault = (sel_addr[BYTE_OFF_W-1:0] != '0) ||
                      ((sel_addr >> BYTE_OFF_W) >= WORD_W'(DEPTH_WORDS));

   mem_lat_counter u_lat_counter (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (accept),
      .load_val_i (CNT_LOAD),
      .dec_i      (state_q == WAIT),
      .zero_o     (cnt_zero)
   );

   always_ff @(posedge clk_i) begin
      if (accept) begin
         we_q    <= we_i;
         addr_q  <= addr_i;
         wdata_q <= wdata_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         ack_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         ack_q   <= 1'b0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         if (enter_resp) begin
            ack_q <= 1'b1;
            err_q <= sel_fault;
            if (!sel_we && !sel_fault) begin
               rdata_q <= mem_q[sel_idx];
            end
         end
         case (state_q)
            IDLE: begin
               if (req_i) begin
                  if (LATENCY == 1) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_zero) begin
                  state_q <= RESP;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // A reset on the RESP-entry edge suppresses the commit along with the ack.
   always_ff @(posedge clk_i) begin
      if (!rst_i && enter_resp && sel_we && !sel_fault) begin
         mem_q[sel_idx] <= sel_wdata;
      end
   end

   assign ready_o = !rst_i && (state_q == IDLE);
   assign ack_o   = ack_q;
   assign rdata_o = rdata_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=4 and a LATENCY=1 instance against a word-array model.
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req   [2];
   logic        we    [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        ready [2];
   logic        ack   [2];
   logic [31:0] rdata [2];
   logic        err   [2];

   int total = 0;
   int bad   = 0;

   localparam int LAT [2] = '{4, 1};
   localparam int DEPTH = 1024;

   logic [31:0] mm [2][DEPTH];
   bit          wr [2][DEPTH];

   typedef struct {
      int          s;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tbl [12];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut4 (
      .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
      .wdata_i(wdata[0]), .ready_o(ready[0]), .ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0])
   );

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
      .wdata_i(wdata[1]), .ready_o(ready[1]), .ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1])
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
      end
   endtask

   function automatic bit is_fault(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
   endfunction

   function automatic logic [31:0] rnd_addr(input int words);
      int          r;
      logic [31:0] a;
      r = int'($urandom_range(0, 9));
      a = 32'($urandom_range(0, words - 1)) << 2;
      if (r == 0) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 1) a = 32'h1000 + (32'($urandom_range(0, 255)) << 2);
      if (r == 2) a = 32'hFFFF_FFFC;
      return a;
   endfunction

   // One complete transaction; the caller supplies the expected response.
   task automatic xact(input int s, input logic we_v, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input bit chk_rd,
                       input string nm);
      int k;
      k = 0;
      while (!ready[s] && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      if (!ready[s]) begin
         check({nm, " ready-timeout"}, 64'(ready[s]), 64'(1));
         return;
      end
      req[s] = 1'b1; we[s] = we_v; addr[s] = a; wdata[s] = wd;
      @(posedge clk); #1;
      req[s] = 1'b0; we[s] = ~we_v; addr[s] = $urandom; wdata[s] = $urandom;
      k = 0;
      while (!ack[s] && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check({nm, " latency"}, 64'(k), 64'(LAT[s] - 1));
      check({nm, " err"}, 64'(err[s]), 64'(exp_err));
      if (chk_rd) check({nm, " rdata"}, 64'(rdata[s]), 64'(exp_rd));
      @(posedge clk); #1;
      check({nm, " after-ack"}, 64'({ack[s], err[s], rdata[s], ready[s]}),
            64'({1'b0, 1'b0, 32'h0, 1'b1}));
   endtask

   task automatic model_store(input int s, input logic we_v, input logic [31:0] a,
                              input logic [31:0] wd);
      if (we_v && !is_fault(a)) begin
         mm[s][int'(a[11:2])] = wd;
         wr[s][int'(a[11:2])] = 1'b1;
      end
   endtask

   task automatic rnd_xact(input int s, input logic we_v, input logic [31:0] a, input string nm);
      logic [31:0] wd;
      logic [31:0] er;
      bit          f;
      bit          cr;
      int          ix;
      wd = $urandom;
      f  = is_fault(a);
      ix = int'(a[11:2]);
      er = 32'h0;
      cr = 1'b1;
      if (!we_v && !f) begin
         er = mm[s][ix];
         cr = wr[s][ix];
      end
      xact(s, we_v, a, wd, er, f, cr, nm);
      model_store(s, we_v, a, wd);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      logic [31:0] al [30];
      logic [31:0] v;
      bit          seen;
      int          k;

      tbl[0]  = '{0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0,          1'b0};
      tbl[1]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          1'b0};
      tbl[2]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  1'b0};
      tbl[3]  = '{0, 1'b0, 32'h0000_0013, 32'h0,         32'h0,          1'b1};
      tbl[4]  = '{0, 1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0,          1'b1};
      tbl[5]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h0BAD_F00D,  1'b0};
      tbl[6]  = '{0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0,          1'b0};
      tbl[7]  = '{0, 1'b0, 32'h0000_0FFC, 32'h0,         32'hCAFE_F00D,  1'b0};
      tbl[8]  = '{1, 1'b1, 32'h0000_0004, 32'hA5A5_A5A5, 32'h0,          1'b0};
      tbl[9]  = '{1, 1'b0, 32'h0000_0004, 32'h0,         32'hA5A5_A5A5,  1'b0};
      tbl[10] = '{1, 1'b0, 32'h0000_0006, 32'h0,         32'h0,          1'b1};
      tbl[11] = '{1, 1'b1, 32'hFFFF_FFFC, 32'h1,         32'h0,          1'b1};

      rst = 1'b1;
      for (int s = 0; s < 2; s++) begin
         req[s] = 1'b0; we[s] = 1'b0; addr[s] = '0; wdata[s] = '0;
      end

      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         for (int s = 0; s < 2; s++)
            check($sformatf("reset dut%0d cyc%0d", s, i),
                  64'({ready[s], ack[s], rdata[s], err[s]}), 64'(0));
      end
      rst = 1'b0;
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++)
         check($sformatf("release dut%0d", s), 64'({ready[s], ack[s], err[s]}),
               64'({1'b1, 1'b0, 1'b0}));

      for (int i = 0; i < 12; i++) begin
         xact(tbl[i].s, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_err,
              1'b1, $sformatf("tbl%0d", i));
         model_store(tbl[i].s, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      end

      for (int w = 0; w < 64; w++)
         rnd_xact(0, 1'b1, 32'(w) << 2, $sformatf("prewrite%0d", w));

      // Request held high: accepts every LATENCY+1 cycles, each ack tied to its own address.
      req[0] = 1'b1; we[0] = 1'b0;
      for (int j = 0; j < 30; j++) begin
         logic        e_rdy;
         logic        e_ack;
         logic [31:0] e_rd;
         e_rdy = ((j % (LAT[0] + 1)) == 0);
         e_ack = (j >= LAT[0]) && ((j % (LAT[0] + 1)) == LAT[0]);
         e_rd  = e_ack ? mm[0][int'(al[j - LAT[0]][11:2])] : 32'h0;
         check($sformatf("busy j%0d", j), 64'({ready[0], ack[0], rdata[0]}),
               64'({e_rdy, e_ack, e_rd}));
         al[j]    = 32'($urandom_range(0, 63)) << 2;
         addr[0]  = al[j];
         wdata[0] = $urandom;
         @(posedge clk); #1;
      end
      req[0] = 1'b0;

      // Reset while WAITing drops the store.
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; wdata[0] = 32'h1234_5678;
      @(posedge clk); #1;
      req[0] = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen |= ack[0];
         @(posedge clk); #1;
      end
      check("midop-rst no-ack", 64'(seen), 64'(0));
      xact(0, 1'b0, 32'h20, 32'h0, mm[0][8], 1'b0, 1'b1, "midop-rst reload");

      // Reset and request on the same edge: request not taken.
      rst = 1'b1; req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h24; wdata[0] = 32'hFEED_FACE;
      @(posedge clk); #1;
      check("rst+req ready", 64'(ready[0]), 64'(0));
      rst = 1'b0; req[0] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         seen |= ack[0];
         @(posedge clk); #1;
      end
      check("rst+req no-ack", 64'(seen), 64'(0));
      xact(0, 1'b0, 32'h24, 32'h0, mm[0][9], 1'b0, 1'b1, "rst+req reload");

      // Reset during RESP: the store was already committed and must survive.
      v = $urandom;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h28; wdata[0] = v;
      @(posedge clk); #1;
      req[0] = 1'b0;
      k = 0;
      while (!ack[0] && k < 40) begin
         @(posedge clk); #1;
         k++;
      end
      check("resp-rst latency", 64'(k), 64'(LAT[0] - 1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("resp-rst ack-cleared", 64'(ack[0]), 64'(0));
      model_store(0, 1'b1, 32'h28, v);
      xact(0, 1'b0, 32'h28, 32'h0, mm[0][10], 1'b0, 1'b1, "resp-rst reload");

      for (int i = 0; i < 40; i++)
         rnd_xact(0, 1'($urandom_range(0, 1)), rnd_addr(64), $sformatf("rnd4_%0d", i));
      for (int i = 0; i < 30; i++)
         rnd_xact(1, 1'($urandom_range(0, 1)), rnd_addr(8), $sformatf("rnd1_%0d", i));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
